// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - byte-serial instruction fetch stage assembling 32-bit little-endian words
// Optional ICACHE_EN macro adds a 16-entry direct-mapped instruction cache.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_in,
    input  logic        pc_rdy_in,
    output logic        pc_stall,
    input  logic        jump_flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_byte_vld,
    input  logic [7:0]  mem_byte,
    input  logic        id_stall,
    output logic        inst_vld,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_count;
    logic [31:0] r_mem_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        w_hit;
    logic [31:0] w_hit_data;

`ifdef ICACHE_EN
    logic [25:0] r_tag   [16];
    logic [31:0] r_data  [16];
    logic [15:0] r_valid;
    logic [3:0]  w_idx;
    logic [3:0]  w_fill_idx;
    logic        w_fill;

    assign w_idx      = pc_in[5:2];
    assign w_fill_idx = r_inst_pc[5:2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == pc_in[31:6]);
    assign w_hit_data = r_data[w_idx];
    // Fill only on the byte-3 edge of an unflushed fetch
    assign w_fill     = rdy && !jump_flush && (r_state == FETCH) &&
                        mem_byte_vld && (r_count == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 16'd0;
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[w_fill_idx]  <= r_inst_pc[31:6];
            r_data[w_fill_idx] <= {mem_byte, r_inst[23:0]};
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (rdy) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (jump_flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (pc_rdy_in) w_next = w_hit ? HOLD : FETCH;
                FETCH:   if (mem_byte_vld && (r_count == 2'd3)) w_next = HOLD;
                HOLD:    if (!id_stall) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_mem_addr <= 32'd0;
            r_inst     <= 32'd0;
            r_inst_pc  <= 32'd0;
        end else if (rdy) begin
            if (jump_flush) begin
                r_count <= 2'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (pc_rdy_in) begin
                            r_inst_pc <= pc_in;
                            if (w_hit) begin
                                r_inst <= w_hit_data;
                            end else begin
                                r_mem_addr <= pc_in;
                                r_count    <= 2'd0;
                            end
                        end
                    end
                    FETCH: begin
                        if (mem_byte_vld) begin
                            r_inst[{r_count, 3'b000} +: 8] <= mem_byte;
                            r_mem_addr <= r_mem_addr + 32'd1;
                            r_count    <= r_count + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_req  = (r_state == FETCH);
    assign pc_stall = (r_state != IDLE);
    assign inst_vld = (r_state == HOLD);
    assign mem_addr = r_mem_addr;
    assign inst     = r_inst;
    assign inst_pc  = r_inst_pc;

endmodule
